// File: rtl/core_pkg.sv
// Shared RV32 core constants: canonical NOP, instruction field positions and
// the base-ISA major opcodes that the hazard scoreboard decodes.
package core_pkg;

   localparam logic [31:0] RV_NOP = 32'h0000_0013;

   localparam int OPC_LSB = 0;
   localparam int OPC_MSB = 6;
   localparam int RD_LSB  = 7;
   localparam int RS1_LSB = 15;
   localparam int RS2_LSB = 20;
   localparam int REG_W   = 5;
   localparam int OPC_W   = 7;

   typedef enum logic [6:0] {
      OPC_LOAD   = 7'b0000011,
      OPC_OP_IMM = 7'b0010011,
      OPC_AUIPC  = 7'b0010111,
      OPC_STORE  = 7'b0100011,
      OPC_OP     = 7'b0110011,
      OPC_LUI    = 7'b0110111,
      OPC_BRANCH = 7'b1100011,
      OPC_JALR   = 7'b1100111,
      OPC_JAL    = 7'b1101111,
      OPC_SYSTEM = 7'b1110011
   } rv_opcode_e;

endpackage

// File: rtl/fetch_buf_mem.sv
// Entry storage for the fetch/decode buffer: one synchronous write port and
// one asynchronous read port. Data is deliberately left unreset.
module fetch_buf_mem #(
   parameter int DEPTH = 4,
   parameter int W     = 64
) (
   input  logic                     clk,
   input  logic                     we_i,
   input  logic [$clog2(DEPTH)-1:0] waddr_i,
   input  logic [W-1:0]             wdata_i,
   input  logic [$clog2(DEPTH)-1:0] raddr_i,
   output logic [W-1:0]             rdata_o
);

   logic [W-1:0] mem_q [DEPTH];

   // Write port
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_decode_buffer.sv
// Instruction buffer between fetch and decode: circular FIFO of {instr, pc}
// whose head fields feed the hazard scoreboard; kill flushes, stall holds.
module fetch_decode_buffer
   import core_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int XLEN  = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     f_valid,
   input  logic [XLEN-1:0]          f_instr,
   input  logic [XLEN-1:0]          f_pc,
   output logic                     f_ready,
   input  logic                     stall,
   input  logic                     kill,
   output logic                     d_valid,
   output logic [XLEN-1:0]          d_instr,
   output logic [XLEN-1:0]          d_pc,
   output logic [6:0]               op_code,
   output logic [4:0]               rd,
   output logic [4:0]               rs1,
   output logic [4:0]               rs2,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              push_s, pop_s;
   logic [2*XLEN-1:0] head_s;

   fetch_buf_mem #(
      .DEPTH (DEPTH),
      .W     (2*XLEN)
   ) u_mem (
      .clk     (clk),
      .we_i    (push_s),
      .waddr_i (wr_ptr_q),
      .wdata_i ({f_instr, f_pc}),
      .raddr_i (rd_ptr_q),
      .rdata_o (head_s)
   );

   assign f_ready = !rst && (count_q != FULL_CNT);
   assign d_valid = (count_q != {CW{1'b0}});
   assign push_s  = f_valid && f_ready && !kill;
   assign pop_s   = d_valid && !stall && !kill;

   // Pointer and occupancy next-state; kill dominates push and pop
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (kill) begin
         wr_ptr_d = {PW{1'b0}};
         rd_ptr_d = {PW{1'b0}};
         count_d  = {CW{1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // State registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= {PW{1'b0}};
         rd_ptr_q <= {PW{1'b0}};
         count_q  <= {CW{1'b0}};
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Empty buffer presents a NOP at pc 0 so the scoreboard sees no hazard
   always_comb begin
      if (d_valid) begin
         d_instr = head_s[2*XLEN-1:XLEN];
         d_pc    = head_s[XLEN-1:0];
      end else begin
         d_instr = XLEN'(RV_NOP);
         d_pc    = {XLEN{1'b0}};
      end
   end

   assign op_code = d_instr[OPC_MSB:OPC_LSB];
   assign rd      = d_instr[RD_LSB  +: REG_W];
   assign rs1     = d_instr[RS1_LSB +: REG_W];
   assign rs2     = d_instr[RS2_LSB +: REG_W];
   assign count   = count_q;

endmodule

// File: tb/tb_fetch_decode_buffer.sv
// Self-checking bench for fetch_decode_buffer: directed steps from the test
// plan plus randomized traffic against a queue-based reference model.
module tb_fetch_decode_buffer;

   localparam int DEPTH = 4;
   localparam int XLEN  = 32;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic            clk = 1'b0;
   logic            rst;
   logic            f_valid;
   logic [XLEN-1:0] f_instr;
   logic [XLEN-1:0] f_pc;
   logic            f_ready;
   logic            stall;
   logic            kill;
   logic            d_valid;
   logic [XLEN-1:0] d_instr;
   logic [XLEN-1:0] d_pc;
   logic [6:0]      op_code;
   logic [4:0]      rd, rs1, rs2;
   logic [2:0]      count;

   int total = 0;
   int bad   = 0;

   logic [63:0] model_q [$];
   logic [31:0] pc_ctr;

   fetch_decode_buffer #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
      .clk(clk), .rst(rst), .f_valid(f_valid), .f_instr(f_instr), .f_pc(f_pc),
      .f_ready(f_ready), .stall(stall), .kill(kill), .d_valid(d_valid),
      .d_instr(d_instr), .d_pc(d_pc), .op_code(op_code), .rd(rd), .rs1(rs1),
      .rs2(rs2), .count(count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Compare every output with the model, then clock once and update the model.
   task automatic cycle(input string tag);
      logic [31:0] ei, ep;
      logic        ev, er, push, pop;
      #1;
      ev = (model_q.size() != 0);
      er = (model_q.size() < DEPTH);
      ei = ev ? model_q[0][63:32] : NOP;
      ep = ev ? model_q[0][31:0]  : 32'h0;
      chk({tag, ".d_valid"}, 64'(d_valid), 64'(ev));
      chk({tag, ".f_ready"}, 64'(f_ready), 64'(er));
      chk({tag, ".count"},   64'(count),   64'(model_q.size()));
      chk({tag, ".d_instr"}, 64'(d_instr), 64'(ei));
      chk({tag, ".d_pc"},    64'(d_pc),    64'(ep));
      chk({tag, ".fields"},  {45'h0, op_code, rd, rs1, rs2},
          {45'h0, ei[6:0], ei[11:7], ei[19:15], ei[24:20]});
      push = f_valid && er && !kill;
      pop  = ev && !stall && !kill;
      @(posedge clk);
      if (kill) begin
         model_q.delete();
      end else begin
         if (pop)  void'(model_q.pop_front());
         if (push) model_q.push_back({f_instr, f_pc});
      end
      #1;
   endtask

   initial begin
      rst = 1'b1; f_valid = 1'b0; f_instr = '0; f_pc = '0; stall = 1'b0; kill = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      // Reset values while rst is high
      chk("rst.f_ready", 64'(f_ready), 64'd0);
      chk("rst.d_valid", 64'(d_valid), 64'd0);
      chk("rst.d_instr", 64'(d_instr), 64'(NOP));
      chk("rst.d_pc",    64'(d_pc),    64'd0);
      chk("rst.count",   64'(count),   64'd0);
      chk("rst.op_code", 64'(op_code), 64'h13);
      chk("rst.regs",    64'({rd, rs1, rs2}), 64'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("idle.f_ready", 64'(f_ready), 64'd1);
      cycle("idle");

      // Single add x3,x1,x2
      f_valid = 1'b1; f_instr = 32'h0020_81B3; f_pc = 32'h100;
      cycle("add.push");
      f_valid = 1'b0;
      #1;
      chk("add.d_valid", 64'(d_valid), 64'd1);
      chk("add.rd",      64'(rd),      64'd3);
      chk("add.rs1",     64'(rs1),     64'd1);
      chk("add.rs2",     64'(rs2),     64'd2);
      chk("add.op_code", 64'(op_code), 64'b0110011);
      cycle("add.pop");
      chk("add.after", 64'(d_valid), 64'd0);

      // Fill under stall, fifth push refused, then drain in order
      stall = 1'b1;
      for (int i = 0; i < 5; i++) begin
         f_valid = 1'b1; f_instr = $urandom; f_pc = 32'h100 + 32'(4 * i);
         cycle("fill");
      end
      f_valid = 1'b0;
      #1;
      chk("full.count",   64'(count),   64'd4);
      chk("full.f_ready", 64'(f_ready), 64'd0);
      stall = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("drain.pc", 64'(d_pc), 64'(32'h100 + 32'(4 * i)));
         cycle("drain");
      end
      chk("drain.empty", 64'(d_valid), 64'd0);

      // Fill 3, kill for 2 cycles with fetch still valid
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         f_valid = 1'b1; f_instr = $urandom; f_pc = 32'h200 + 32'(4 * i);
         cycle("kfill");
      end
      kill = 1'b1; f_instr = 32'hDEAD_BEEF; f_pc = 32'h300;
      cycle("kill1");
      cycle("kill2");
      kill = 1'b0; f_valid = 1'b0;
      #1;
      chk("kill.count",   64'(count),   64'd0);
      chk("kill.d_valid", 64'(d_valid), 64'd0);
      chk("kill.f_ready", 64'(f_ready), 64'd1);
      f_valid = 1'b1; f_instr = 32'h0041_0233; f_pc = 32'h400;
      cycle("postkill");
      f_valid = 1'b0;
      #1;
      chk("postkill.pc", 64'(d_pc), 64'h400);
      stall = 1'b0;
      cycle("postkill.pop");

      // Continuous push and pop across pointer wrap
      for (int i = 0; i < 10; i++) begin
         f_valid = 1'b1; f_instr = $urandom; f_pc = 32'h500 + 32'(4 * i);
         cycle("stream");
         if (i > 0) chk("stream.pc", 64'(d_pc), 64'(32'h500 + 32'(4 * i)));
         chk("stream.count", 64'(count), 64'd1);
      end
      f_valid = 1'b0;
      cycle("stream.tail");

      // Asynchronous reset mid-stream with two entries held
      stall = 1'b1;
      for (int i = 0; i < 2; i++) begin
         f_valid = 1'b1; f_instr = $urandom; f_pc = 32'h600 + 32'(4 * i);
         cycle("arst.fill");
      end
      f_valid = 1'b0;
      #1;
      chk("arst.pre", 64'(count), 64'd2);
      rst = 1'b1;
      #1;
      chk("arst.d_valid", 64'(d_valid), 64'd0);
      chk("arst.count",   64'(count),   64'd0);
      chk("arst.f_ready", 64'(f_ready), 64'd0);
      model_q.delete();
      @(posedge clk); #1;
      rst = 1'b0; stall = 1'b0;

      // Randomized traffic
      pc_ctr = 32'h1000;
      for (int i = 0; i < 400; i++) begin
         f_valid = ($urandom_range(0, 3) != 0);
         stall   = ($urandom_range(0, 2) == 0);
         kill    = ($urandom_range(0, 19) == 0);
         f_instr = $urandom;
         f_pc    = pc_ctr;
         pc_ctr  = pc_ctr + 32'd4;
         cycle("rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
